multicycle_ctrl: RTL and testbench

//  Multicycle MIPS-subset control FSM; next generation of the single-cycle opcode/func decoder.

---
 rtl/ctrl_pkg.sv | 85 ++++++++
 rtl/ctrl_decode.sv | 53 +++++
 rtl/multicycle_ctrl.sv | 254 +++++++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle MIPS-subset controller: opcodes, R-type funcs,
// ALU operation codes, FSM states, instruction classes and datapath mux selects.
package ctrl_pkg;

    // Opcodes (IR[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // R-type func codes (IR[5:0])
    localparam logic [5:0] FN_SLL = 6'b000000;
    localparam logic [5:0] FN_SRL = 6'b000010;
    localparam logic [5:0] FN_JR  = 6'b001000;
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_XOR = 6'b100110;
    localparam logic [5:0] FN_NOR = 6'b100111;
    localparam logic [5:0] FN_SLT = 6'b101010;

    // ALU operation codes
    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_OR  = 4'b0011;
    localparam logic [3:0] ALU_NOR = 4'b0100;
    localparam logic [3:0] ALU_XOR = 4'b0101;
    localparam logic [3:0] ALU_SLT = 4'b0110;
    localparam logic [3:0] ALU_SGT = 4'b0111;
    localparam logic [3:0] ALU_SLL = 4'b1000;
    localparam logic [3:0] ALU_SRL = 4'b1001;
    localparam logic [3:0] ALU_BEQ = 4'b1010;
    localparam logic [3:0] ALU_BNE = 4'b1011;
    localparam logic [3:0] ALU_NOP = 4'b1111;

    // PC source select
    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;
    localparam logic [1:0] PC_SRC_RS     = 2'b11;

    // ALU B operand select
    localparam logic [1:0] SRC_B_RT     = 2'b00;
    localparam logic [1:0] SRC_B_FOUR   = 2'b01;
    localparam logic [1:0] SRC_B_IMM    = 2'b10;
    localparam logic [1:0] SRC_B_IMM_SH = 2'b11;

    // Trap causes
    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

    typedef enum logic [2:0] {
        StRst,
        StFetch,
        StDecode,
        StExec,
        StMem,
        StWb,
        StTrap
    } state_e;

    typedef enum logic [3:0] {
        ClsIllegal,
        ClsRAlu,
        ClsIAlu,
        ClsLw,
        ClsSw,
        ClsBranch,
        ClsJ,
        ClsJal,
        ClsJr
    } instr_cls_e;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational instruction decoder: opcode/func -> instruction class, ALU op, illegal flag.
module ctrl_decode
    import ctrl_pkg::*;
#(
    parameter int unsigned OPCODE_W = 6,
    parameter int unsigned FUNC_W   = 6,
    parameter int unsigned ALUOP_W  = 4
) (
    input  logic [OPCODE_W-1:0] opcode_i,
    input  logic [FUNC_W-1:0]   func_i,
    output logic [ALUOP_W-1:0]  alu_op_o,
    output instr_cls_e          cls_o,
    output logic                illegal_o
);

    // Classify the instruction and pick the ALU op used in the execute step.
    always_comb begin
        cls_o    = ClsIllegal;
        alu_op_o = ALU_NOP;
        case (opcode_i)
            OP_RTYPE: begin
                cls_o = ClsRAlu;
                case (func_i)
                    FN_ADD:  alu_op_o = ALU_ADD;
                    FN_SUB:  alu_op_o = ALU_SUB;
                    FN_AND:  alu_op_o = ALU_AND;
                    FN_OR:   alu_op_o = ALU_OR;
                    FN_NOR:  alu_op_o = ALU_NOR;
                    FN_XOR:  alu_op_o = ALU_XOR;
                    FN_SLT:  alu_op_o = ALU_SLT;
                    FN_SLL:  alu_op_o = ALU_SLL;
                    FN_SRL:  alu_op_o = ALU_SRL;
                    FN_JR:   cls_o    = ClsJr;
                    default: cls_o    = ClsIllegal;
                endcase
            end
            OP_ADDI: begin cls_o = ClsIAlu;   alu_op_o = ALU_ADD; end
            OP_SLTI: begin cls_o = ClsIAlu;   alu_op_o = ALU_SLT; end
            OP_ANDI: begin cls_o = ClsIAlu;   alu_op_o = ALU_AND; end
            OP_ORI:  begin cls_o = ClsIAlu;   alu_op_o = ALU_OR;  end
            OP_XORI: begin cls_o = ClsIAlu;   alu_op_o = ALU_XOR; end
            OP_LW:   begin cls_o = ClsLw;     alu_op_o = ALU_ADD; end
            OP_SW:   begin cls_o = ClsSw;     alu_op_o = ALU_ADD; end
            OP_BEQ:  begin cls_o = ClsBranch; alu_op_o = ALU_BEQ; end
            OP_BNE:  begin cls_o = ClsBranch; alu_op_o = ALU_BNE; end
            OP_J:    cls_o = ClsJ;
            OP_JAL:  cls_o = ClsJal;
            default: cls_o = ClsIllegal;
        endcase
        illegal_o = (cls_o == ClsIllegal);
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-subset control FSM: fetch/decode/exec/mem/writeback sequencing with a
// memory wait handshake, bounded memory timeout and a sticky trap state.
// Optional CTRL_PERF_CNT_EN adds cycle_cnt/instr_cnt performance counters.
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int unsigned OPCODE_W    = 6,
    parameter int unsigned FUNC_W      = 6,
    parameter int unsigned ALUOP_W     = 4,
    parameter int unsigned MEM_TIMEOUT = 15
`ifdef CTRL_PERF_CNT_EN
    ,
    parameter int unsigned CNT_W       = 32
`endif
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic [FUNC_W-1:0]   func,
    input  logic                mem_ready,
    output logic                mem_read,
    output logic                mem_write,
    output logic                iord,
    output logic                ir_write,
    output logic                pc_write,
    output logic                pc_write_cond,
    output logic [1:0]          pc_src,
    output logic                alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [ALUOP_W-1:0]  alu_op,
    output logic                reg_dst,
    output logic                mem_to_reg,
    output logic                reg_write,
    output logic                jal,
    output logic                trap,
    output logic [1:0]          trap_cause
`ifdef CTRL_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]    cycle_cnt,
    output logic [CNT_W-1:0]    instr_cnt
`endif
);

    localparam int unsigned      TMO_W    = $clog2(MEM_TIMEOUT + 1);
    // Last wait count at which mem_ready may still rescue the access.
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MEM_TIMEOUT - 1);

    state_e             state_q, state_d;
    logic [TMO_W-1:0]   wait_q, wait_d;
    logic [1:0]         cause_q, cause_d;

    logic [ALUOP_W-1:0] dec_alu_op;
    instr_cls_e         dec_cls;
    logic               dec_illegal;

    ctrl_decode #(
        .OPCODE_W (OPCODE_W),
        .FUNC_W   (FUNC_W),
        .ALUOP_W  (ALUOP_W)
    ) u_decode (
        .opcode_i  (opcode),
        .func_i    (func),
        .alu_op_o  (dec_alu_op),
        .cls_o     (dec_cls),
        .illegal_o (dec_illegal)
    );

    // Next-state, wait counter, trap cause and all datapath strobes.
    always_comb begin
        state_d       = state_q;
        wait_d        = wait_q;
        cause_d       = cause_q;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        iord          = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_src        = PC_SRC_ALU;
        alu_src_a     = 1'b0;
        alu_src_b     = SRC_B_RT;
        alu_op        = ALU_NOP;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        jal           = 1'b0;
        trap          = 1'b0;

        unique case (state_q)
            StRst: state_d = StFetch;

            StFetch: begin
                mem_read  = 1'b1;
                alu_src_b = SRC_B_FOUR;
                alu_op    = ALU_ADD;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    pc_src   = PC_SRC_ALU;
                    state_d  = StDecode;
                end else if (wait_q == TMO_LAST) begin
                    state_d = StTrap;
                    cause_d = CAUSE_TIMEOUT;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end

            StDecode: begin
                // Branch target computed speculatively into ALUOut.
                alu_src_b = SRC_B_IMM_SH;
                alu_op    = ALU_ADD;
                if (dec_illegal) begin
                    state_d = StTrap;
                    cause_d = CAUSE_ILLEGAL;
                end else begin
                    case (dec_cls)
                        ClsJ: begin
                            pc_write = 1'b1;
                            pc_src   = PC_SRC_JUMP;
                            state_d  = StFetch;
                        end
                        ClsJal: begin
                            pc_write  = 1'b1;
                            pc_src    = PC_SRC_JUMP;
                            reg_write = 1'b1;
                            jal       = 1'b1;
                            state_d   = StFetch;
                        end
                        ClsJr: begin
                            pc_write = 1'b1;
                            pc_src   = PC_SRC_RS;
                            state_d  = StFetch;
                        end
                        default: state_d = StExec;
                    endcase
                end
            end

            StExec: begin
                alu_src_a = 1'b1;
                case (dec_cls)
                    ClsRAlu: begin
                        alu_src_b = SRC_B_RT;
                        alu_op    = dec_alu_op;
                        state_d   = StWb;
                    end
                    ClsIAlu: begin
                        alu_src_b = SRC_B_IMM;
                        alu_op    = dec_alu_op;
                        state_d   = StWb;
                    end
                    ClsLw, ClsSw: begin
                        alu_src_b = SRC_B_IMM;
                        alu_op    = ALU_ADD;
                        state_d   = StMem;
                    end
                    ClsBranch: begin
                        alu_src_b     = SRC_B_RT;
                        alu_op        = dec_alu_op;
                        pc_write_cond = 1'b1;
                        pc_src        = PC_SRC_ALUOUT;
                        state_d       = StFetch;
                    end
                    default: begin
                        // Only reachable if the IR changed under us; treat as illegal.
                        state_d = StTrap;
                        cause_d = CAUSE_ILLEGAL;
                    end
                endcase
            end

            StMem: begin
                iord = 1'b1;
                if (dec_cls == ClsSw) begin
                    mem_write = 1'b1;
                end else begin
                    mem_read = 1'b1;
                end
                if (mem_ready) begin
                    state_d = (dec_cls == ClsSw) ? StFetch : StWb;
                end else if (wait_q == TMO_LAST) begin
                    state_d = StTrap;
                    cause_d = CAUSE_TIMEOUT;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end

            StWb: begin
                reg_write  = 1'b1;
                reg_dst    = (dec_cls == ClsRAlu);
                mem_to_reg = (dec_cls == ClsLw);
                state_d    = StFetch;
            end

            StTrap: trap = 1'b1;

            default: state_d = StRst;
        endcase

        // Any state change restarts the wait budget for the next memory phase.
        if (state_d != state_q) begin
            wait_d = '0;
        end
    end

    assign trap_cause = cause_q;

    // State, wait counter and sticky trap cause registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StRst;
            wait_q  <= '0;
            cause_q <= CAUSE_NONE;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            cause_q <= cause_d;
        end
    end

`ifdef CTRL_PERF_CNT_EN
    logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
    logic [CNT_W-1:0] instr_cnt_q, instr_cnt_d;

    // Count non-trap cycles and instruction completions (re-entry into fetch).
    always_comb begin
        cycle_cnt_d = cycle_cnt_q;
        instr_cnt_d = instr_cnt_q;
        if (state_q != StTrap) begin
            cycle_cnt_d = cycle_cnt_q + 1'b1;
        end
        if ((state_d == StFetch) && (state_q != StFetch) && (state_q != StRst)) begin
            instr_cnt_d = instr_cnt_q + 1'b1;
        end
    end

    // Performance counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt_q <= '0;
            instr_cnt_q <= '0;
        end else begin
            cycle_cnt_q <= cycle_cnt_d;
            instr_cnt_q <= instr_cnt_d;
        end
    end

    assign cycle_cnt = cycle_cnt_q;
    assign instr_cnt = instr_cnt_q;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: per-instruction expected output timelines built from the
// instruction-level rules, checked every cycle, plus literal pins on key cycles.
module tb_multicycle_ctrl;

    typedef struct packed {
        logic       mem_read;
        logic       mem_write;
        logic       iord;
        logic       ir_write;
        logic       pc_write;
        logic       pc_write_cond;
        logic [1:0] pc_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [3:0] alu_op;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       jal;
        logic       trap;
        logic [1:0] trap_cause;
    } out_t;

    localparam int TMO = 15;
    localparam int C_ILL = 0, C_R = 1, C_I = 2, C_LW = 3, C_SW = 4, C_BR = 5;
    localparam int C_J = 6, C_JAL = 7, C_JR = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] opcode = '0;
    logic [5:0] func = '0;
    logic       mem_ready = 1'b0;

    logic       mem_read, mem_write, iord, ir_write, pc_write, pc_write_cond;
    logic [1:0] pc_src, alu_src_b, trap_cause;
    logic       alu_src_a, reg_dst, mem_to_reg, reg_write, jal, trap;
    logic [3:0] alu_op;
    out_t       act;

    multicycle_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .opcode        (opcode),
        .func          (func),
        .mem_ready     (mem_ready),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .iord          (iord),
        .ir_write      (ir_write),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .pc_src        (pc_src),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .reg_dst       (reg_dst),
        .mem_to_reg    (mem_to_reg),
        .reg_write     (reg_write),
        .jal           (jal),
        .trap          (trap),
        .trap_cause    (trap_cause)
    );

    assign act = {mem_read, mem_write, iord, ir_write, pc_write, pc_write_cond, pc_src,
                  alu_src_a, alu_src_b, alu_op, reg_dst, mem_to_reg, reg_write, jal, trap,
                  trap_cause};

    always #5 clk = ~clk;

    int    n_chk = 0;
    int    n_fail = 0;
    logic  chk_en = 1'b0;
    logic  lit_en = 1'b0;
    out_t  exp_v = '0;
    out_t  lit_v = '0;
    string tag = "";
    string lit_tag = "";

    // ---------------- instruction-level model ----------------
    function automatic int cls_of(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            6'b000000: begin
                case (fn)
                    6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100110, 6'b100111,
                    6'b101010, 6'b000000, 6'b000010: return C_R;
                    6'b001000: return C_JR;
                    default:   return C_ILL;
                endcase
            end
            6'b001000, 6'b001010, 6'b001100, 6'b001101, 6'b001110: return C_I;
            6'b100011: return C_LW;
            6'b101011: return C_SW;
            6'b000100, 6'b000101: return C_BR;
            6'b000010: return C_J;
            6'b000011: return C_JAL;
            default:   return C_ILL;
        endcase
    endfunction

    function automatic logic [3:0] alu_of(input logic [5:0] op, input logic [5:0] fn);
        if (op == 6'b000000) begin
            case (fn)
                6'b100000: return 4'b0000;
                6'b100010: return 4'b0001;
                6'b100100: return 4'b0010;
                6'b100101: return 4'b0011;
                6'b100111: return 4'b0100;
                6'b100110: return 4'b0101;
                6'b101010: return 4'b0110;
                6'b000000: return 4'b1000;
                6'b000010: return 4'b1001;
                default:   return 4'b1111;
            endcase
        end
        case (op)
            6'b001010: return 4'b0110;
            6'b001100: return 4'b0010;
            6'b001101: return 4'b0011;
            6'b001110: return 4'b0101;
            6'b000100: return 4'b1010;
            6'b000101: return 4'b1011;
            default:   return 4'b0000;
        endcase
    endfunction

    function automatic out_t e_idle();
        out_t o = '0;
        o.alu_op = 4'b1111;
        return o;
    endfunction

    function automatic out_t e_trap(input logic [1:0] cause);
        out_t o = e_idle();
        o.trap = 1'b1;
        o.trap_cause = cause;
        return o;
    endfunction

    function automatic out_t e_fetch(input logic rdy);
        out_t o = '0;
        o.mem_read = 1'b1;
        o.alu_src_b = 2'b01;
        o.alu_op = 4'b0000;
        o.ir_write = rdy;
        o.pc_write = rdy;
        return o;
    endfunction

    function automatic out_t e_decode(input logic [5:0] op, input logic [5:0] fn);
        out_t o = '0;
        int   c = cls_of(op, fn);
        o.alu_src_b = 2'b11;
        o.alu_op = 4'b0000;
        if (c == C_J || c == C_JAL || c == C_JR) o.pc_write = 1'b1;
        if (c == C_J || c == C_JAL) o.pc_src = 2'b10;
        if (c == C_JR) o.pc_src = 2'b11;
        if (c == C_JAL) begin
            o.reg_write = 1'b1;
            o.jal = 1'b1;
        end
        return o;
    endfunction

    function automatic out_t e_exec(input logic [5:0] op, input logic [5:0] fn);
        out_t o = '0;
        int   c = cls_of(op, fn);
        o.alu_src_a = 1'b1;
        if (c == C_R || c == C_BR) begin
            o.alu_src_b = 2'b00;
            o.alu_op = alu_of(op, fn);
        end else if (c == C_I) begin
            o.alu_src_b = 2'b10;
            o.alu_op = alu_of(op, fn);
        end else begin
            o.alu_src_b = 2'b10;
            o.alu_op = 4'b0000;
        end
        if (c == C_BR) begin
            o.pc_write_cond = 1'b1;
            o.pc_src = 2'b01;
        end
        return o;
    endfunction

    function automatic out_t e_mem(input logic [5:0] op, input logic [5:0] fn);
        out_t o = e_idle();
        o.iord = 1'b1;
        if (cls_of(op, fn) == C_SW) o.mem_write = 1'b1;
        else o.mem_read = 1'b1;
        return o;
    endfunction

    function automatic out_t e_wb(input logic [5:0] op, input logic [5:0] fn);
        out_t o = e_idle();
        o.reg_write = 1'b1;
        o.reg_dst = (cls_of(op, fn) == C_R);
        o.mem_to_reg = (cls_of(op, fn) == C_LW);
        return o;
    endfunction

    // ---------------- compare process ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                n_chk = n_chk + 1;
                if (act !== exp_v) begin
                    n_fail = n_fail + 1;
                    $display("FAIL %s @%0t: got %b want %b", tag, $time, act, exp_v);
                end
            end
            if (lit_en) begin
                n_chk = n_chk + 1;
                if (act !== lit_v) begin
                    n_fail = n_fail + 1;
                    $display("FAIL pin %s @%0t: got %b want %b", lit_tag, $time, act, lit_v);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic pin(input out_t v, input string name);
        lit_v = v;
        lit_tag = name;
        lit_en = 1'b1;
    endtask

    // One cycle: drive at posedge+1, checked at negedge, return at next posedge+1.
    task automatic step(input logic rst, input logic rdy, input out_t e, input string name);
        rst_n = rst;
        mem_ready = rdy;
        exp_v = e;
        tag = name;
        chk_en = 1'b1;
        @(posedge clk);
        #1;
        lit_en = 1'b0;
    endtask

    task automatic do_reset(input string name);
        pin(22'b0_0_0_0_0_0_00_0_00_1111_0_0_0_0_0_00, {name, "_reset"});
        step(1'b0, 1'b0, e_idle(), {name, "_rst0"});
        step(1'b0, 1'b1, e_idle(), {name, "_rst1"});
        step(1'b1, 1'b0, e_idle(), {name, "_rel"});
    endtask

    task automatic hold_trap(input int n, input logic [1:0] cause, input int pin_at,
                             input out_t pin_v, input string name);
        for (int i = 0; i < n; i++) begin
            if (i == pin_at) pin(pin_v, name);
            step(1'b1, i[0], e_trap(cause), name);
        end
    endtask

    task automatic run(input logic [5:0] op, input logic [5:0] fn, input int fwait,
                       input int mwait, input int pin_at, input out_t pin_v, input string name);
        out_t eq[$];
        logic rq[$];
        int   c;
        c = cls_of(op, fn);
        for (int i = 0; i < fwait && i < TMO; i++) begin
            eq.push_back(e_fetch(1'b0));
            rq.push_back(1'b0);
        end
        if (fwait >= TMO) begin
            eq.push_back(e_trap(2'b10));
            rq.push_back(1'b0);
        end else begin
            eq.push_back(e_fetch(1'b1));
            rq.push_back(1'b1);
            eq.push_back(e_decode(op, fn));
            rq.push_back(1'b0);
            if (c == C_ILL) begin
                eq.push_back(e_trap(2'b01));
                rq.push_back(1'b0);
            end else if (c != C_J && c != C_JAL && c != C_JR) begin
                eq.push_back(e_exec(op, fn));
                rq.push_back(1'b0);
                if (c == C_LW || c == C_SW) begin
                    for (int i = 0; i < mwait && i < TMO; i++) begin
                        eq.push_back(e_mem(op, fn));
                        rq.push_back(1'b0);
                    end
                    if (mwait >= TMO) begin
                        eq.push_back(e_trap(2'b10));
                        rq.push_back(1'b0);
                    end else begin
                        eq.push_back(e_mem(op, fn));
                        rq.push_back(1'b1);
                        if (c == C_LW) begin
                            eq.push_back(e_wb(op, fn));
                            rq.push_back(1'b0);
                        end
                    end
                end else if (c != C_BR) begin
                    eq.push_back(e_wb(op, fn));
                    rq.push_back(1'b0);
                end
            end
        end
        opcode = op;
        func = fn;
        foreach (eq[k]) begin
            if (k == pin_at) pin(pin_v, name);
            step(1'b1, rq[k], eq[k], name);
        end
    endtask

    initial begin
        out_t none;
        none = '0;
        @(posedge clk);
        #1;
        do_reset("init");

        run(6'b000000, 6'b100000, 0, 0, 3, 22'b0_0_0_0_0_0_00_0_00_1111_1_0_1_0_0_00, "add");
        run(6'b000000, 6'b100010, 2, 0, -1, none, "sub_fwait2");
        run(6'b001101, 6'b010101, 0, 0, -1, none, "ori");
        run(6'b100011, 6'b000000, 0, 3, 7, 22'b0_0_0_0_0_0_00_0_00_1111_0_1_1_0_0_00, "lw");
        run(6'b000100, 6'b000000, 0, 0, 2, 22'b0_0_0_0_0_1_01_1_00_1010_0_0_0_0_0_00, "beq");
        run(6'b000000, 6'b100101, 0, 0, 0, 22'b1_0_0_1_1_0_00_0_01_0000_0_0_0_0_0_00, "or_after_beq");
        run(6'b000101, 6'b000000, 0, 0, -1, none, "bne");
        run(6'b000011, 6'b000000, 0, 0, 1, 22'b0_0_0_0_1_0_10_0_11_0000_0_0_1_1_0_00, "jal");
        run(6'b000010, 6'b000000, 0, 0, -1, none, "j");
        run(6'b000000, 6'b001000, 0, 0, -1, none, "jr");
        run(6'b101011, 6'b000000, 0, 1, -1, none, "sw");
        run(6'b000000, 6'b000000, 0, 0, -1, none, "sll");
        run(6'b001010, 6'b000000, 0, 14, -1, none, "slti");
        run(6'b000000, 6'b100000, 14, 0, -1, none, "add_fwait14");
        run(6'b100011, 6'b000000, 0, 14, -1, none, "lw_mwait14");

        run(6'b111111, 6'b000000, 0, 0, -1, none, "illegal_op");
        hold_trap(20, 2'b01, 19, 22'b0_0_0_0_0_0_00_0_00_1111_0_0_0_0_1_01, "illegal_hold");
        do_reset("after_illegal");

        run(6'b000000, 6'b111111, 0, 0, -1, none, "illegal_func");
        hold_trap(3, 2'b01, -1, none, "illegal_func_hold");
        do_reset("after_illegal_func");

        run(6'b000000, 6'b100000, 15, 0, 0, 22'b1_0_0_0_0_0_00_0_01_0000_0_0_0_0_0_00, "fetch_tmo");
        hold_trap(3, 2'b10, 1, 22'b0_0_0_0_0_0_00_0_00_1111_0_0_0_0_1_10, "fetch_tmo_hold");
        do_reset("after_fetch_tmo");

        run(6'b101011, 6'b000000, 0, 15, -1, none, "sw_mem_tmo");
        hold_trap(2, 2'b10, -1, none, "sw_mem_tmo_hold");
        do_reset("after_mem_tmo");

        // Reset asserted while a store is waiting on memory.
        opcode = 6'b101011;
        func = 6'b000000;
        step(1'b1, 1'b1, e_fetch(1'b1), "midsw_f");
        step(1'b1, 1'b0, e_decode(6'b101011, 6'b000000), "midsw_d");
        step(1'b1, 1'b0, e_exec(6'b101011, 6'b000000), "midsw_e");
        step(1'b1, 1'b0, e_mem(6'b101011, 6'b000000), "midsw_m");
        do_reset("midsw");
        run(6'b000000, 6'b100110, 0, 0, -1, none, "xor_after_reset");

        chk_en = 1'b0;
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
